// File: rtl/bank_sched_pkg.sv
// Shared types and helpers for the bank burst sequencer: FSM states,
// default geometry and the bank-group/bank to flat bank index mapping.
package bank_sched_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRE    = 3'd1,
      ACT    = 3'd2,
      BURST  = 3'd3,
      RDWAIT = 3'd4,
      DONE   = 3'd5
   } state_e;

   localparam int BGWIDTH_DEF   = 2;
   localparam int BAWIDTH_DEF   = 2;
   localparam int ADDRWIDTH_DEF = 17;
   localparam int COLWIDTH_DEF  = 10;
   localparam int NBANKS        = (2 ** BGWIDTH_DEF) * (2 ** BAWIDTH_DEF);
   localparam int ROWS          = 2 ** ADDRWIDTH_DEF;
   localparam int COLS          = 2 ** COLWIDTH_DEF;

   // Phase counter width; every timing parameter must stay below 2**CNTW - 1.
   localparam int CNTW = 8;

   function automatic int bank_index(input int bg, input int ba, input int banks_per_group);
      return bg * banks_per_group + ba;
   endfunction

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: one {valid, row} entry per bank with lookup,
// set and clear ports, and a flattened view of the rows currently held open.
module open_row_table #(
   parameter int  NBANKS    = 16,
   parameter int  ADDRWIDTH = 17,
   localparam int BIW       = $clog2(NBANKS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BIW-1:0]              lk_idx,
   input  logic [ADDRWIDTH-1:0]        lk_row,
   output logic                        lk_hit,
   output logic                        lk_closed,
   input  logic                        set_en,
   input  logic [BIW-1:0]              set_idx,
   input  logic [ADDRWIDTH-1:0]        set_row,
   input  logic                        clr_en,
   input  logic [BIW-1:0]              clr_idx,
   output logic [NBANKS*ADDRWIDTH-1:0] rows_o
);

   logic [NBANKS-1:0]                 vld_q, vld_d;
   logic [NBANKS-1:0][ADDRWIDTH-1:0] row_q, row_d;

   always_comb begin
      vld_d = vld_q;
      row_d = row_q;
      for (int b = 0; b < NBANKS; b++) begin
         if (clr_en && clr_idx == BIW'(b)) vld_d[b] = 1'b0;
         if (set_en && set_idx == BIW'(b)) begin
            vld_d[b] = 1'b1;
            row_d[b] = set_row;
         end
      end
   end

   always_comb begin
      lk_hit    = 1'b0;
      lk_closed = 1'b0;
      rows_o    = '0;
      for (int b = 0; b < NBANKS; b++) begin
         if (lk_idx == BIW'(b)) begin
            lk_closed = !vld_q[b];
            lk_hit    = vld_q[b] && (row_q[b] == lk_row);
         end
         // Closed banks present row 0 so idle buses stay quiet.
         if (vld_q[b]) rows_o[b*ADDRWIDTH +: ADDRWIDTH] = row_q[b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         row_q <= '0;
      end else begin
         vld_q <= vld_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/bank_burst_sequencer.sv
// Single-requester DRAM burst controller: precharge/activate/burst sequencing
// against an open-row table, driving the chip's flattened per-bank buses.
module bank_burst_sequencer
   import bank_sched_pkg::*;
#(
   parameter int BGWIDTH      = BGWIDTH_DEF,
   parameter int BAWIDTH      = BAWIDTH_DEF,
   parameter int ADDRWIDTH    = ADDRWIDTH_DEF,
   parameter int COLWIDTH     = COLWIDTH_DEF,
   parameter int DEVICE_WIDTH = 4,
   parameter int BL           = 8,
   parameter int TRP          = 2,
   parameter int TRCD         = 2,
   parameter int RL           = 1
) (
   input  logic                                                        clk,
   input  logic                                                        rst,
   input  logic                                                        req_valid,
   output logic                                                        req_ready,
   input  logic                                                        req_wr,
   input  logic [BGWIDTH-1:0]                                          req_bg,
   input  logic [BAWIDTH-1:0]                                          req_ba,
   input  logic [ADDRWIDTH-1:0]                                        req_row,
   input  logic [COLWIDTH-1:0]                                         req_col,
   input  logic [BL*DEVICE_WIDTH-1:0]                                  req_wdata,
   output logic                                                        done,
   output logic [BL*DEVICE_WIDTH-1:0]                                  rdata,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)-1:0]                        rd_o_wr,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)*ADDRWIDTH-1:0]              row,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)*COLWIDTH-1:0]               column,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)*DEVICE_WIDTH-1:0]           dqin,
   input  logic [(2**BGWIDTH)*(2**BAWIDTH)*DEVICE_WIDTH-1:0]           dqout
);

   localparam int BANKSPERGROUP = 2 ** BAWIDTH;
   localparam int NB            = (2 ** BGWIDTH) * BANKSPERGROUP;
   localparam int BIW           = $clog2(NB);
   localparam int DW            = DEVICE_WIDTH;

   state_e                    state_q, state_d;
   logic [CNTW-1:0]           cnt_q, cnt_d;
   logic                      wr_q, wr_d;
   logic [BIW-1:0]            bank_q, bank_d;
   logic [ADDRWIDTH-1:0]      row_q, row_d;
   logic [COLWIDTH-1:0]       col_q, col_d;
   logic [BL*DW-1:0]          wdata_q, wdata_d;
   logic [BL*DW-1:0]          rbuf_q, rbuf_d;
   logic [BL*DW-1:0]          rdata_q, rdata_d;

   logic [BIW-1:0]            req_bank;
   logic                      accept, lk_hit, lk_closed, set_en, clr_en;
   logic [NB*ADDRWIDTH-1:0]   tbl_rows;
   logic [DW-1:0]             wbeat, bank_dq;
   logic [CNTW-1:0]           cap_t;

   assign req_bank = BIW'(bank_index(int'(req_bg), int'(req_ba), BANKSPERGROUP));
   assign accept   = req_valid && (state_q == IDLE);
   assign clr_en   = accept && !lk_hit && !lk_closed;
   assign set_en   = (state_q == ACT) && (cnt_q == CNTW'(TRCD - 1));

   open_row_table #(.NBANKS(NB), .ADDRWIDTH(ADDRWIDTH)) u_tbl (
      .clk       (clk),
      .rst       (rst),
      .lk_idx    (req_bank),
      .lk_row    (req_row),
      .lk_hit    (lk_hit),
      .lk_closed (lk_closed),
      .set_en    (set_en),
      .set_idx   (bank_q),
      .set_row   (row_q),
      .clr_en    (clr_en),
      .clr_idx   (req_bank),
      .rows_o    (tbl_rows)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = lk_hit ? BURST : (lk_closed ? ACT : PRE);
         PRE:     if (cnt_q == CNTW'(TRP - 1))  state_d = ACT;
         ACT:     if (cnt_q == CNTW'(TRCD - 1)) state_d = BURST;
         BURST:   if (cnt_q == CNTW'(BL - 1))   state_d = (!wr_q && RL > 0) ? RDWAIT : DONE;
         RDWAIT:  if (cnt_q == CNTW'(RL - 1))   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: request latch, phase counter, read capture and rdata hand-off.
   always_comb begin
      cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      wr_d    = wr_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      wdata_d = wdata_q;
      if (accept) begin
         wr_d    = req_wr;
         bank_d  = req_bank;
         row_d   = req_row;
         col_d   = req_col;
         wdata_d = req_wdata;
      end

      bank_dq = '0;
      for (int b = 0; b < NB; b++)
         if (bank_q == BIW'(b)) bank_dq = dqout[b*DW +: DW];

      // cap_t counts cycles since beat 0 was driven; beat k lands at k+RL.
      cap_t  = (state_q == RDWAIT) ? CNTW'(BL) + cnt_q : cnt_q;
      rbuf_d = rbuf_q;
      for (int k = 0; k < BL; k++)
         if (!wr_q && (state_q == BURST || state_q == RDWAIT) && cap_t == CNTW'(k + RL))
            rbuf_d[k*DW +: DW] = bank_dq;

      rdata_d = rdata_q;
      if (state_d == DONE && state_q != DONE && !wr_q) rdata_d = rbuf_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         bank_q  <= bank_d;
         row_q   <= row_d;
         col_q   <= col_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      wbeat = '0;
      for (int k = 0; k < BL; k++)
         if (cnt_q == CNTW'(k)) wbeat = wdata_q[k*DW +: DW];
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      done      = (state_q == DONE);
      rdata     = rdata_q;
      rd_o_wr   = '0;
      row       = tbl_rows;
      column    = '0;
      dqin      = '0;
      for (int b = 0; b < NB; b++) begin
         if (bank_q == BIW'(b)) begin
            // The table only learns the new row when ACT completes.
            if (state_q == ACT) row[b*ADDRWIDTH +: ADDRWIDTH] = row_q;
            if (state_q == BURST) begin
               rd_o_wr[b]                       = wr_q;
               column[b*COLWIDTH +: COLWIDTH]   = col_q + COLWIDTH'(cnt_q);
               if (wr_q) dqin[b*DW +: DW]       = wbeat;
            end
         end
      end
   end

endmodule

// File: tb/tb_bank_burst_sequencer.sv
// Bench for bank_burst_sequencer: a DRAM chip stand-in on the buses, directed
// vectors, multi-cycle corner sequences and random traffic against a request-level model.
module tb_bank_burst_sequencer;

   localparam int NB = 16, AW = 17, CW = 10, DW = 4, BL = 8, TRP = 2, TRCD = 2, RL = 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid, req_ready, req_wr, done;
   logic [1:0]         req_bg, req_ba;
   logic [AW-1:0]      req_row;
   logic [CW-1:0]      req_col;
   logic [BL*DW-1:0]   req_wdata, rdata;
   logic [NB-1:0]      rd_o_wr;
   logic [NB*AW-1:0]   row;
   logic [NB*CW-1:0]   column;
   logic [NB*DW-1:0]   dqin, dqout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bank_burst_sequencer #(
      .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(AW), .COLWIDTH(CW), .DEVICE_WIDTH(DW),
      .BL(BL), .TRP(TRP), .TRCD(TRCD), .RL(RL)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
      .req_wdata(req_wdata), .done(done), .rdata(rdata), .rd_o_wr(rd_o_wr), .row(row),
      .column(column), .dqin(dqin), .dqout(dqout)
   );

   // Unwritten cells read back a fixed pattern so reads of fresh rows are predictable.
   function automatic logic [3:0] init_val(input int b, input int r, input int c);
      return 4'((b * 7 + r * 3 + c * 5) & 15);
   endfunction

   // Chip stand-in: stores on rd_o_wr, returns data one cycle later (RL = 1).
   bit [3:0] chip_mem [NB][8][1024];
   bit       chip_wr  [NB][8][1024];
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         int r, c;
         r = int'(row[b*AW +: 3]);
         c = int'(column[b*CW +: CW]);
         if (rd_o_wr[b]) begin
            chip_mem[b][r][c] <= dqin[b*DW +: DW];
            chip_wr[b][r][c]  <= 1'b1;
         end
         dqout[b*DW +: DW] <= chip_wr[b][r][c] ? chip_mem[b][r][c] : init_val(b, r, c);
      end
   end

   // Request-level reference: open row per bank (-1 = closed) and memory contents.
   int       open_row [NB];
   bit [3:0] model_mem [NB][8][1024];
   bit       model_wr  [NB][8][1024];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input bit wr, input int bank, input int r, input int c,
                        input logic [31:0] wd, input bit hold,
                        output int lat, output logic [31:0] rd);
      int elat, s, n, busy_rdy, bad, idx, cc;
      logic [31:0] erd;
      bit hit, closed;
      int cols[$], wrs[$], rws[$];
      hit    = (open_row[bank] == r);
      closed = (open_row[bank] < 0);
      elat   = BL + (wr ? 0 : RL) + 1 + (hit ? 0 : (closed ? TRCD : TRP + TRCD));
      for (int k = 0; k < BL; k++) begin
         cc = (c + k) % 1024;
         erd[k*4 +: 4] = model_wr[bank][r][cc] ? model_mem[bank][r][cc] : init_val(bank, r, cc);
         if (wr) begin
            model_mem[bank][r][cc] = wd[k*4 +: 4];
            model_wr[bank][r][cc]  = 1'b1;
         end
      end
      open_row[bank] = r;

      @(negedge clk);
      check("ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_wr = wr;
      req_bg = 2'(bank / 4); req_ba = 2'(bank % 4);
      req_row = AW'(r); req_col = CW'(c); req_wdata = wd;
      @(posedge clk);
      #1 if (!hold) req_valid = 1'b0;
      n = 0; busy_rdy = 0; lat = -1;
      while (n < 100) begin
         @(negedge clk);
         n++;
         cols.push_back(int'(column[bank*CW +: CW]));
         wrs.push_back(int'(rd_o_wr[bank]));
         rws.push_back(int'(row[bank*AW +: AW]));
         if (done) begin
            lat = n;
            break;
         end
         if (req_ready) busy_rdy++;
      end
      check("latency", 64'(lat), 64'(elat));
      check("busy_ready", 64'(busy_rdy), 64'd0);
      rd = rdata;
      if (!wr) check("rdata", 64'(rdata), 64'(erd));
      s = elat - (wr ? 0 : RL) - BL;
      bad = 0;
      for (int k = 0; k < BL; k++) begin
         idx = s - 1 + k;
         if (idx >= cols.size()) bad++;
         else if (cols[idx] != (c + k) % 1024 || wrs[idx] != int'(wr) || rws[idx] != r) bad++;
      end
      check("burst_bus", 64'(bad), 64'd0);
      if (!hit) check("cycle1_row", 64'(rws[0]), 64'(closed ? r : 0));
   endtask

   typedef struct {
      bit          wr;
      int          bank;
      int          r;
      int          c;
      logic [31:0] wd;
      int          exp_lat;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   initial begin
      vec_t        vecs[8];
      int          lat;
      logic [31:0] rd;

      req_valid = 1'b0; req_wr = 1'b0; req_bg = '0; req_ba = '0;
      req_row = '0; req_col = '0; req_wdata = '0;
      foreach (open_row[i]) open_row[i] = -1;

      vecs[0] = '{1'b1, 5, 1, 0,     32'h89ABCDEF, 11, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 5, 1, 0,     32'h0,        10, 1'b1, 32'h89ABCDEF};
      vecs[2] = '{1'b0, 5, 2, 0,     32'h0,        14, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 5, 2, 10'h3FE, 32'h13579BDF, 9, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 5, 2, 10'h3FE, 32'h0,      10, 1'b1, 32'h13579BDF};
      vecs[5] = '{1'b1, 0, 7, 5,     32'h2468ACE0, 11, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 0, 3, 5,     32'h0,        14, 1'b0, 32'h0};
      vecs[7] = '{1'b0, 5, 2, 10'h3FE, 32'h0,      10, 1'b1, 32'h13579BDF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_buses", 64'({|rd_o_wr, |row, |column, |dqin}), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].wr, vecs[i].bank, vecs[i].r, vecs[i].c, vecs[i].wd, 1'b0, lat, rd);
         check("vec_lat", 64'(lat), 64'(vecs[i].exp_lat));
         if (vecs[i].chk_rd) check("vec_rdata", 64'(rd), 64'(vecs[i].exp_rd));
      end

      // req_valid held through a burst: second acceptance only after done.
      issue(1'b1, 5, 2, 16, 32'hCAFEF00D, 1'b1, lat, rd);
      issue(1'b1, 5, 2, 16, 32'hCAFEF00D, 1'b0, lat, rd);
      check("held_second_lat", 64'(lat), 64'd9);

      // Reset in the middle of a read burst, at beat 3.
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_bg = 2'd1; req_ba = 2'd1;
      req_row = AW'(2); req_col = '0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_col_beat3", 64'(column[5*CW +: CW]), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 64'(req_ready), 64'd1);
      check("midrst_buses", 64'({|rd_o_wr, |row, |column, |dqin}), 64'd0);
      check("midrst_rdata", 64'(rdata), 64'd0);
      foreach (open_row[i]) open_row[i] = -1;
      issue(1'b0, 5, 2, 10'h3FE, 32'h0, 1'b0, lat, rd);
      check("post_rst_lat", 64'(lat), 64'd12);

      for (int i = 0; i < 40; i++) begin
         int b, r, c;
         b = $urandom_range(0, 15);
         r = $urandom_range(0, 3);
         c = ($urandom_range(0, 1) == 1) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023);
         issue(1'($urandom_range(0, 1)), b, r, c, $urandom, 1'b0, lat, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bank_burst_sequencer.md
Name: bank_burst_sequencer

Overview:
Single-requester burst controller sitting in front of the DRAM Chip model. It accepts one read or write burst request at a time and tracks an open row per bank. It sequences precharge/activate/burst phases with cycle-count timing, drives the Chip's flattened per-bank rd_o_wr/row/column/dqin buses, and collects dqout beats into a returned read burst.

Parameters:
BGWIDTH, 2, bank-group address bits (BANKGROUPS = 2**BGWIDTH)
BAWIDTH, 2, bank-in-group bits (BANKSPERGROUP = 2**BAWIDTH; NBANKS = BANKGROUPS*BANKSPERGROUP)
ADDRWIDTH, 17, row address bits
COLWIDTH, 10, column bits
DEVICE_WIDTH, 4, data bits per beat
BL, 8, beats per burst
TRP, 2, precharge cycles (>=1)
TRCD, 2, activate-to-column cycles (>=1)
RL, 1, cycles from column drive to valid dqout (>=0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_wr  in  1  1=write, 0=read
req_bg  in  BGWIDTH  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ADDRWIDTH  row
req_col  in  COLWIDTH  start column
req_wdata  in  BL*DEVICE_WIDTH  write burst, beat k = bits [k*DW +: DW]
done  out  1  one-cycle pulse, request complete
rdata  out  BL*DEVICE_WIDTH  read burst, valid with done for reads, held until next done
rd_o_wr  out  NBANKS  per-bank write strobe to Chip
row  out  NBANKS*ADDRWIDTH  per-bank row to Chip
column  out  NBANKS*COLWIDTH  per-bank column to Chip
dqin  out  NBANKS*DEVICE_WIDTH  per-bank write data to Chip
dqout  in  NBANKS*DEVICE_WIDTH  per-bank read data from Chip

Behaviour:
- Bank index b = req_bg*BANKSPERGROUP + req_ba; slice b of every bus belongs to that bank.
- Reset (synchronous, any state incl. mid-burst): state=IDLE, open-row table all closed, all bus outputs 0, done=0, rdata=0, req_ready=1 on the cycle after reset deasserts.
- Accept on edge with req_valid&&req_ready; all req_* latched; req_ready drops next cycle.
- States: IDLE -> (row hit) BURST | (bank closed) ACT | (other row open) PRE -> ACT -> BURST -> RDWAIT (reads only, RL cycles; skipped if RL=0 or write) -> DONE -> IDLE.
- PRE: TRP cycles; target bank row slice = 0, table entry marked closed on entry.
- ACT: TRCD cycles; target row slice = latched row; table entry set open/row on exit.
- BURST: BL cycles; beat k drives column slice = (req_col + k) mod 2**COLWIDTH (wraps, no carry into row); rd_o_wr[b] = req_wr; dqin slice = wdata beat k for writes, 0 for reads.
- Read capture: dqout slice b sampled RL cycles after beat k is driven -> rdata beat k.
- DONE: done=1 for exactly one cycle; rdata updated for reads, unchanged for writes.
- Idle/non-target banks: rd_o_wr=0, column=0, dqin=0; row slice = table row if open, else 0 (open rows stay driven).
- Latency (accept edge = cycle 0, done cycle): hit = BL+RLr+1; closed = TRCD+BL+RLr+1; miss = TRP+TRCD+BL+RLr+1, where RLr = RL for reads, 0 for writes.
- req_valid while busy is ignored; no queueing.
- No refresh, no auto-precharge; rows stay open until a conflicting request.

Decomposition:
- Package bank_sched_pkg: state enum (IDLE, PRE, ACT, BURST, RDWAIT, DONE), derived localparams NBANKS/ROWS/COLS, bank-index function.
- Sub-module open_row_table: NBANKS entries {valid, row}; lookup (hit/closed/miss), set, clear, synchronous clear on rst.

Test Plan:
- Reset mid-BURST (assert rst at beat 3) -> next cycle all buses 0, req_ready=1; next request to same bank/row takes ACT path (table cleared).
- Write bg1 ba1 row 0x1 col 0, closed bank, BL=8, TRCD=2 -> ACT cycles 1-2, column slice 5 = 0..7 in cycles 3-10 with rd_o_wr[5]=1, done at cycle 11.
- Read same bank/row col 0, RL=1 -> row hit, no ACT, column 0..7 in cycles 1-8, done at cycle 10, rdata equals written data.
- Read bank 5 row 0x2 after row 0x1 open -> PRE 2 cycles (row slice 5 = 0), ACT 2 cycles (row=0x2), done at cycle 14.
- Write col 0x3FE, BL=8 -> columns 0x3FE, 0x3FF, 0x000..0x005; row slice unchanged.
- req_valid held high throughout a burst -> exactly one acceptance per IDLE; second accepted on the cycle after done.
